// File: rtl/rom_accum.sv
// Scan sequencer for the 8x4 ROM: walks every address once per start request,
// accumulating the sum of all entries and the first-occurring maximum.
module rom_accum #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        ROM_addr,
    input  logic [DATA_W-1:0]        ROM_data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic [DATA_W-1:0]        max_val,
    output logic [ADDR_W-1:0]        max_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t state;
    state_t state_next;

    logic step;

    // A scan cycle only advances when not paused.
    assign step = (state == SCAN) && !hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (step && (ROM_addr == LAST_ADDR)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ROM_addr <= '0;
            sum      <= '0;
            max_val  <= '0;
            max_addr <= '0;
        end else if ((state == IDLE) && start) begin
            ROM_addr <= '0;
            sum      <= '0;
            max_val  <= '0;
            max_addr <= '0;
        end else if (step) begin
            sum <= sum + {{ADDR_W{1'b0}}, ROM_data};
            // Strict compare keeps the earliest address on ties.
            if (ROM_data > max_val) begin
                max_val  <= ROM_data;
                max_addr <= ROM_addr;
            end
            // The last address wraps naturally back to 0 for the next scan.
            ROM_addr <= ROM_addr + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rom_accum.sv
// Self-checking bench for rom_accum: table of scan vectors (directed + random)
// checked against a plain-arithmetic model, plus hand-written corner sequences.
module tb_rom_accum;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int NUM    = 1 << ADDR_W;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     hold;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic                     busy;
    logic                     done;
    logic [DATA_W+ADDR_W-1:0] sum;
    logic [DATA_W-1:0]        max_val;
    logic [ADDR_W-1:0]        max_addr;

    logic [DATA_W-1:0] rom_mem [NUM];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] img;       // entry a lives in img[4a +: 4]
        logic [2:0]  hold_addr;
        logic [1:0]  hold_len;
        logic [6:0]  exp_sum;
        logic [3:0]  exp_max;
        logic [2:0]  exp_addr;
        logic [4:0]  exp_lat;
    } vec_t;

    localparam logic [31:0] SPEC_IMG = 32'h1F90_7F52; // 2,5,15,7,0,9,15,1

    vec_t vecs [12];

    rom_accum #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hold     (hold),
        .ROM_addr (rom_addr),
        .ROM_data (rom_data),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .max_val  (max_val),
        .max_addr (max_addr)
    );

    assign rom_data = rom_mem[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int entry(input logic [31:0] img, input int a);
        return int'(img[4*a +: 4]);
    endfunction

    function automatic int ref_sum(input logic [31:0] img);
        int s = 0;
        for (int a = 0; a < NUM; a++) s += entry(img, a);
        return s;
    endfunction

    function automatic int ref_max(input logic [31:0] img);
        int m = 0;
        for (int a = 0; a < NUM; a++) if (entry(img, a) > m) m = entry(img, a);
        return m;
    endfunction

    function automatic int ref_first(input logic [31:0] img);
        int m = ref_max(img);
        for (int a = 0; a < NUM; a++) if (entry(img, a) == m) return a;
        return 0;
    endfunction

    task automatic load_rom(input logic [31:0] img);
        for (int a = 0; a < NUM; a++) rom_mem[a] = img[4*a +: 4];
    endtask

    // One-cycle start pulse, then watch the scan cycle by cycle at negedges.
    task automatic run_scan(input int id, input vec_t v);
        int    addr_q[$];
        int    busy_cnt = 0;
        int    done_cnt = 0;
        int    lat      = -1;
        int    held     = 0;
        int    reps;
        int    exp_a;
        string tag;
        tag = $sformatf("vec%0d", id);
        for (int a = 0; a < NUM; a++) begin
            reps = (a == int'(v.hold_addr)) ? int'(v.hold_len) + 1 : 1;
            for (int r = 0; r < reps; r++) addr_q.push_back(a);
        end
        load_rom(v.img);
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= int'(v.exp_lat) + 3; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = cyc;
                check({tag, " sum at done"}, 32'(sum), 32'(v.exp_sum));
                check({tag, " max_val at done"}, 32'(max_val), 32'(v.exp_max));
                check({tag, " max_addr at done"}, 32'(max_addr), 32'(v.exp_addr));
            end else if (busy) begin
                exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                check($sformatf("%s ROM_addr cycle %0d", tag, cyc), 32'(rom_addr), 32'(exp_a));
            end
            if (busy && !done && int'(rom_addr) == int'(v.hold_addr) && held < int'(v.hold_len)) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
            end
            @(negedge clk);
        end
        hold = 1'b0;
        check({tag, " done latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " done pulse count"}, 32'(done_cnt), 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(v.exp_lat));
        check({tag, " addresses left"}, 32'(addr_q.size()), 32'd0);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        check({tag, " ROM_addr idle"}, 32'(rom_addr), 32'd0);
        check({tag, " sum held"}, 32'(sum), 32'(v.exp_sum));
        check({tag, " max_addr held"}, 32'(max_addr), 32'(v.exp_addr));
    endtask

    initial begin
        int done_cnt;
        int found;
        logic [31:0] img;
        int h;

        rst_n = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        load_rom(SPEC_IMG);

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{img: SPEC_IMG,     hold_addr: 3'd0, hold_len: 2'd0, exp_sum: 7'd54,  exp_max: 4'd15, exp_addr: 3'd2, exp_lat: 5'd9};
        vecs[1] = '{img: SPEC_IMG,     hold_addr: 3'd4, hold_len: 2'd3, exp_sum: 7'd54,  exp_max: 4'd15, exp_addr: 3'd2, exp_lat: 5'd12};
        vecs[2] = '{img: 32'h0,        hold_addr: 3'd0, hold_len: 2'd0, exp_sum: 7'd0,   exp_max: 4'd0,  exp_addr: 3'd0, exp_lat: 5'd9};
        vecs[3] = '{img: 32'hFFFF_FFFF, hold_addr: 3'd0, hold_len: 2'd0, exp_sum: 7'd120, exp_max: 4'd15, exp_addr: 3'd0, exp_lat: 5'd9};
        // Random contents and pauses, expectations from the model.
        for (int i = 4; i < 12; i++) begin
            img = $urandom();
            h   = $urandom_range(0, 3);
            vecs[i] = '{img: img, hold_addr: 3'($urandom_range(0, NUM - 1)), hold_len: 2'(h),
                        exp_sum: 7'(ref_sum(img)), exp_max: 4'(ref_max(img)),
                        exp_addr: 3'(ref_first(img)), exp_lat: 5'(NUM + 1 + h)};
        end

        // Asynchronous reset mid-cycle, well away from any clock edge.
        #12 rst_n = 1'b0;
        #1;
        check("reset ROM_addr", 32'(rom_addr), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset max_val", 32'(max_val), 32'd0);
        check("reset max_addr", 32'(max_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("busy after reset release", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) run_scan(i, vecs[i]);

        // start held high: back-to-back scans with one IDLE cycle between.
        load_rom(SPEC_IMG);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) done_cnt++;
            if (cyc == 9 || cyc == 19) begin
                check($sformatf("b2b done cycle %0d", cyc), 32'(done), 32'd1);
                check($sformatf("b2b sum cycle %0d", cyc), 32'(sum), 32'd54);
            end
            if (cyc == 10 || cyc == 20) begin
                check($sformatf("b2b idle gap cycle %0d", cyc), 32'(busy), 32'd0);
                check($sformatf("b2b sum held cycle %0d", cyc), 32'(sum), 32'd54);
            end
            if (cyc == 11) check("b2b sum cleared", 32'(sum), 32'd0);
            if (cyc == 20) start = 1'b0;
            @(negedge clk);
        end
        check("b2b done pulses", 32'(done_cnt), 32'd2);
        check("b2b stays idle", 32'(busy), 32'd0);

        // Reset while ROM_addr=5: abort, no done pulse, then a clean scan.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
            if (busy && rom_addr == 3'd5) found = 1;
            else @(negedge clk);
        end
        check("abort reached addr 5", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort ROM_addr", 32'(rom_addr), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort max_val", 32'(max_val), 32'd0);
        check("abort max_addr", 32'(max_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        check("abort no done or busy after reset", 32'(done_cnt), 32'd0);
        run_scan(100, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_accum.md
# rom_accum

Sequencer that sits directly upstream of the 8x4 `rom` block. It drives the ROM address bus and consumes the returned data. On a `start` request it walks every ROM location once, from address 0 to the last address. While walking, it accumulates the sum of all entries and tracks the largest entry and the address where it first occurs. It reports completion with a one-cycle `done` pulse and holds the results stable until the next scan.

## Interface
Parameters:
- `ADDR_W`, default 3: ROM address width; the scan covers 2^ADDR_W locations.
- `DATA_W`, default 4: ROM data width.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  scan request; sampled only in IDLE.
- `hold`  in  1  pause; while high in SCAN, the address, sum and max are frozen.
- `ROM_addr`  out  ADDR_W  address to the ROM; registered.
- `ROM_data`  in  DATA_W  data from the ROM; combinational from `ROM_addr`, valid in the same cycle.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse when the scan completes.
- `sum`  out  DATA_W+ADDR_W  sum of all entries; this width cannot overflow.
- `max_val`  out  DATA_W  largest entry seen.
- `max_addr`  out  ADDR_W  address of the first occurrence of `max_val`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `ROM_addr` = 0.
  - `start`=1 on an edge → SCAN, and in the same edge: `sum`←0, `max_val`←0, `max_addr`←0, `ROM_addr`←0.
  - `start`=0 → stay in IDLE.
- SCAN, each edge with `hold`=0:
  - `sum` ← `sum` + `ROM_data`, zero-extended.
  - If `ROM_data` > `max_val` (strictly greater): `max_val` ← `ROM_data`, `max_addr` ← `ROM_addr`. Ties keep the earlier address.
  - If `ROM_addr` < 2^ADDR_W−1: `ROM_addr` increments.
  - If `ROM_addr` = 2^ADDR_W−1: `ROM_addr` wraps to 0 and the state goes to DONE.
- SCAN, edge with `hold`=1: no register changes. `hold` has no effect in IDLE or DONE.
- DONE: `done`=1 for exactly this cycle, then unconditional → IDLE.
- `start` is ignored in SCAN and DONE. It is not queued; a `start` still high on the IDLE cycle after DONE begins a new scan.
- `sum`, `max_val` and `max_addr` keep their last values in IDLE and are only cleared by a new `start` or by reset.
- If every entry is 0: `max_val`=0, `max_addr`=0.

## Timing
- Reset values, applied immediately when `rst_n` falls, independent of `clk`:
  - state = IDLE.
  - `ROM_addr`=0, `busy`=0, `done`=0, `sum`=0, `max_val`=0, `max_addr`=0.
- Reset asserted mid-SCAN or in DONE: the partial scan is aborted and all outputs take the reset values. No `done` pulse is produced.
- `busy` and `done` are decoded from registered state and are glitch-free.
- Latency with `hold`=0 (edge E0 samples `start`):
  - SCAN occupies the cycles after E0 … E(2^ADDR_W−1), one ROM location per cycle.
  - `done` is high in the cycle after edge E(2^ADDR_W), i.e. the 9th cycle after the start edge for ADDR_W=3.
  - IDLE is reached again after edge E(2^ADDR_W+1).
- Each cycle `hold` is high in SCAN adds exactly one cycle to that latency.
- The final `sum`, `max_val` and `max_addr` are valid in the same cycle `done` is high.

## Test plan
ROM model contents, addresses 0–7: 2, 5, 15, 7, 0, 9, 15, 1.

1. Reset: assert `rst_n`=0 asynchronously, mid-cycle → all outputs 0 immediately; after release, `busy`=0.
2. Full scan: pulse `start` for one cycle, `hold`=0 →
   - `ROM_addr` steps 0..7 on consecutive cycles.
   - `done` pulses exactly once, 9 cycles after the start edge.
   - `sum`=54, `max_val`=15, `max_addr`=2 (tie at address 6 rejected).
   - `busy` is high for 9 cycles.
3. Hold: same as scenario 2 but with `hold`=1 for 3 cycles while `ROM_addr`=4 → `ROM_addr` stays at 4 for 4 cycles; `done` arrives 12 cycles after start; results identical to scenario 2.
4. Start while busy: keep `start` high continuously → back-to-back scans separated by one IDLE cycle; `sum` clears to 0 at each new start; every scan ends with `sum`=54.
5. Reset mid-operation: drop `rst_n` while `ROM_addr`=5 →
   - All outputs go to 0, state returns to IDLE, no `done` pulse.
   - A following `start` produces a clean scan with `sum`=54.
6. All-zero ROM, then all-0xF ROM →
   - All-zero: `sum`=0, `max_val`=0, `max_addr`=0.
   - All-0xF: `sum`=120 (no overflow of the 7-bit result), `max_val`=15, `max_addr`=0.
